// File: rtl/steer_delay_gen.sv
// rtl/steer_delay_gen.sv - beam-steering angle index to per-element delay stream
// Looks up sin(angle), scales it to an inter-element step and emits one delay per element.
module steer_delay_gen #(
   parameter int ANGLE_WIDTH  = 7,
   parameter int SIN_WIDTH    = 16,
   parameter int NUM_ELEMENTS = 4,
   parameter int DELAY_SCALE  = 2915,
   parameter int DELAY_WIDTH  = 16
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            start_in,
   input  logic [ANGLE_WIDTH-1:0]          angle_in,
   input  logic                            dir_in,
   output logic [ANGLE_WIDTH-1:0]          lut_angle_out,
   input  logic [SIN_WIDTH-1:0]            lut_sin_in,
   output logic [DELAY_WIDTH-1:0]          delay_out,
   output logic [$clog2(NUM_ELEMENTS)-1:0] delay_idx_out,
   output logic                            delay_valid_out,
   input  logic                            delay_ready_in,
   output logic                            delay_last_out,
   output logic                            busy_out,
   output logic                            done_out
);

   localparam int IDX_W  = $clog2(NUM_ELEMENTS);
   localparam int PROD_W = SIN_WIDTH + $clog2(DELAY_SCALE + 1) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      SCALE  = 2'd2,
      EMIT   = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [ANGLE_WIDTH-1:0] angle_q;
   logic                   dir_q;
   logic [SIN_WIDTH-1:0]   sin_q;
   logic [DELAY_WIDTH-1:0] step_q;
   logic [DELAY_WIDTH-1:0] acc_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   done_q;

   logic [PROD_W-1:0]      prod;
   logic [DELAY_WIDTH-1:0] step_calc;
   logic [DELAY_WIDTH-1:0] acc_init;
   logic                   xfer;
   logic                   is_last;

   assign xfer    = (state == EMIT) && delay_ready_in;
   assign is_last = (idx_q == LAST_IDX);

   // Full-width product plus half an LSB of the sine scale gives round-half-up.
   assign prod      = PROD_W'(DELAY_SCALE) * PROD_W'(sin_q) + (PROD_W'(1) << (SIN_WIDTH - 1));
   assign step_calc = DELAY_WIDTH'(prod >> SIN_WIDTH);
   assign acc_init  = dir_q ? DELAY_WIDTH'(NUM_ELEMENTS - 1) * step_calc : '0;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_in) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = SCALE;
         SCALE:   state_nxt = EMIT;
         EMIT:    if (xfer && is_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         angle_q <= '0;
         dir_q   <= 1'b0;
         sin_q   <= '0;
         step_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  angle_q <= angle_in;
                  dir_q   <= dir_in;
               end
            end
            LOOKUP: begin
               sin_q <= lut_sin_in;
            end
            SCALE: begin
               step_q <= step_calc;
               acc_q  <= acc_init;
               idx_q  <= '0;
            end
            EMIT: begin
               if (xfer) begin
                  // Final element leaves the accumulator untouched so it never wraps.
                  if (is_last) begin
                     done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                     acc_q <= dir_q ? acc_q - step_q : acc_q + step_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      delay_valid_out = 1'b0;
      delay_last_out  = 1'b0;
      busy_out        = 1'b0;
      case (state)
         IDLE: ;
         EMIT: begin
            delay_valid_out = 1'b1;
            delay_last_out  = is_last;
            busy_out        = 1'b1;
         end
         default: busy_out = 1'b1;
      endcase
   end

   assign lut_angle_out = angle_q;
   assign delay_out     = acc_q;
   assign delay_idx_out = idx_q;
   assign done_out      = done_q;

endmodule

// File: tb/tb_steer_delay_gen.sv
// tb/tb_steer_delay_gen.sv - self-checking bench for steer_delay_gen
// Table vectors, random sets against an arithmetic model, and hand-written corner sequences.
module tb_steer_delay_gen;

   localparam int AW = 7;
   localparam int SW = 16;
   localparam int NE = 4;
   localparam int DS = 2915;
   localparam int DW = 16;
   localparam int IW = 2;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          start_in;
   logic [AW-1:0] angle_in;
   logic          dir_in;
   logic [AW-1:0] lut_angle_out;
   logic [SW-1:0] lut_sin_in;
   logic [DW-1:0] delay_out;
   logic [IW-1:0] delay_idx_out;
   logic          delay_valid_out;
   logic          delay_ready_in;
   logic          delay_last_out;
   logic          busy_out;
   logic          done_out;

   int errors = 0;
   int checks = 0;

   typedef logic [NE-1:0][DW-1:0] dvec_t;
   typedef struct packed {
      logic [AW-1:0] angle;
      logic          dir;
      logic          rnd;
      dvec_t         exp;
   } vec_t;

   steer_delay_gen #(
      .ANGLE_WIDTH(AW), .SIN_WIDTH(SW), .NUM_ELEMENTS(NE), .DELAY_SCALE(DS), .DELAY_WIDTH(DW)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .angle_in(angle_in), .dir_in(dir_in),
      .lut_angle_out(lut_angle_out), .lut_sin_in(lut_sin_in), .delay_out(delay_out),
      .delay_idx_out(delay_idx_out), .delay_valid_out(delay_valid_out),
      .delay_ready_in(delay_ready_in), .delay_last_out(delay_last_out),
      .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   // 2^AW entries across 0..180 degrees, 65535 = 1.0
   function automatic int sin_lut(input int a);
      real r;
      r = 65535.0 * $sin(real'(a) * 3.14159265358979 / 128.0);
      return $rtoi(r + 0.5);
   endfunction

   always_comb lut_sin_in = SW'(sin_lut(int'(lut_angle_out)));

   function automatic dvec_t model(input int a, input logic d);
      longint step;
      dvec_t  v;
      step = (longint'(DS) * longint'(sin_lut(a)) + 32768) / 65536;
      for (int e = 0; e < NE; e++)
         v[e] = DW'(d ? longint'(NE - 1 - e) * step : longint'(e) * step);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start_set(input logic [AW-1:0] a, input logic d);
      start_in = 1'b1;
      angle_in = a;
      dir_in   = d;
      tick();
      start_in = 1'b0;
      angle_in = AW'($urandom);
      dir_in   = 1'($urandom);
      check("lookup_busy", busy_out, 1);
      check("lookup_angle", lut_angle_out, a);
      check("lookup_valid", delay_valid_out, 0);
   endtask

   // Entered at the LOOKUP sample point; returns at the sample point of the done cycle.
   task automatic collect(input dvec_t exp, input logic rnd, input logic inject,
                          input logic timing, input logic [AW-1:0] a);
      int            n     = 0;
      int            cyc   = 1;
      int            first = -1;
      logic          held  = 1'b0;
      logic [DW-1:0] pd    = '0;
      logic [IW-1:0] pi    = '0;
      logic          pl    = 1'b0;
      while (n < NE && cyc < 80) begin
         if (delay_valid_out) begin
            if (first < 0) first = cyc;
            check("idx", delay_idx_out, n);
            check("delay", delay_out, exp[n]);
            check("last", delay_last_out, n == NE - 1);
            if (held) check("stall_hold", {delay_out, delay_idx_out, delay_last_out}, {pd, pi, pl});
            pd = delay_out;
            pi = delay_idx_out;
            pl = delay_last_out;
         end else if (first >= 0) begin
            check("valid_drop", delay_valid_out, 1);
         end
         delay_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inject && first >= 0 && cyc - first == 1) begin
            start_in = 1'b1;
            angle_in = a ^ 7'h15;
         end else begin
            start_in = 1'b0;
         end
         held = delay_valid_out && !delay_ready_in;
         if (delay_valid_out && delay_ready_in) n++;
         tick();
         cyc++;
      end
      start_in = 1'b0;
      check("transfer_count", n, NE);
      check("done_pulse", done_out, 1);
      check("done_valid", delay_valid_out, 0);
      check("done_busy", busy_out, 0);
      if (timing) begin
         check("first_valid_cycle", first, 3);
         check("done_cycle", cyc, NE + 3);
      end
   endtask

   task automatic after_done(input logic [AW-1:0] a);
      tick();
      check("done_one_cycle", done_out, 0);
      check("idle_after", busy_out, 0);
      check("angle_hold", lut_angle_out, a);
   endtask

   initial begin
      vec_t  tbl [6];
      dvec_t v;
      logic [AW-1:0] ra;
      logic rd;

      rst_in = 1'b1;
      start_in = 1'b0;
      angle_in = '0;
      dir_in = 1'b0;
      delay_ready_in = 1'b0;
      repeat (3) tick();
      rst_in = 1'b0;
      tick();
      check("rst_valid", delay_valid_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      check("rst_last", delay_last_out, 0);
      check("rst_angle", lut_angle_out, 0);
      check("rst_delay", delay_out, 0);
      check("rst_idx", delay_idx_out, 0);

      tbl[0] = '{7'd64, 1'b0, 1'b0, {16'd8745, 16'd5830, 16'd2915, 16'd0}};
      tbl[1] = '{7'd32, 1'b0, 1'b0, {16'd6183, 16'd4122, 16'd2061, 16'd0}};
      tbl[2] = '{7'd0,  1'b0, 1'b0, {16'd0,    16'd0,    16'd0,    16'd0}};
      tbl[3] = '{7'd64, 1'b1, 1'b0, {16'd0,    16'd2915, 16'd5830, 16'd8745}};
      tbl[4] = '{7'd96, 1'b0, 1'b1, {16'd6183, 16'd4122, 16'd2061, 16'd0}};
      tbl[5] = '{7'd32, 1'b1, 1'b1, {16'd0,    16'd2061, 16'd4122, 16'd6183}};
      for (int i = 0; i < 6; i++) begin
         start_set(tbl[i].angle, tbl[i].dir);
         collect(tbl[i].exp, tbl[i].rnd, 1'b0, !tbl[i].rnd, tbl[i].angle);
         after_done(tbl[i].angle);
      end

      // start pulsed mid-stream must be neither taken nor queued
      start_set(7'd64, 1'b0);
      collect(tbl[0].exp, 1'b1, 1'b1, 1'b0, 7'd64);
      after_done(7'd64);

      // start accepted in the done cycle
      start_set(7'd64, 1'b0);
      collect(tbl[0].exp, 1'b0, 1'b0, 1'b1, 7'd64);
      start_set(7'd32, 1'b1);
      collect(tbl[5].exp, 1'b0, 1'b0, 1'b1, 7'd32);
      after_done(7'd32);

      for (int k = 0; k < 12; k++) begin
         ra = AW'($urandom);
         rd = 1'($urandom);
         v  = model(int'(ra), rd);
         start_set(ra, rd);
         collect(v, 1'b1, 1'b0, 1'b0, ra);
         after_done(ra);
      end

      // reset in the middle of emission aborts with no done pulse
      start_set(7'd64, 1'b0);
      delay_ready_in = 1'b1;
      tick();
      tick();
      check("pre_rst_valid", delay_valid_out, 1);
      tick();
      check("pre_rst_idx", delay_idx_out, 1);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      check("abort_valid", delay_valid_out, 0);
      check("abort_busy", busy_out, 0);
      check("abort_done", done_out, 0);
      check("abort_angle", lut_angle_out, 0);
      tick();
      check("abort_no_done", done_out, 0);
      check("abort_idle", busy_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
